ifetch: RTL
===========

# ifetch

Instruction fetch stage, directly downstream of the program counter register. It issues single-outstanding read requests on the instruction bus and tracks the fetch address itself: it seeds from `pc_in` after reset, increments by 4 per delivered instruction, and redirects on jumps. It delivers instruction/address pairs to the IF/ID decode boundary. Hold, jump-flush and bus wait states are handled here. `fetch_stall_o` holds the PC whenever no instruction is delivered.

## Interface
- `ADDR_W`, 32: instruction address width (`InstAddressBus`).
- `INST_W`, 32: instruction width (`InstBus`).
- `NOP_INST`, 32'h0000_0013: bubble value (`InstNop`, `addi x0,x0,0`).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_in`  in  ADDR_W  current PC; sampled only on leaving S_IDLE.
- `jump_flag_in`  in  1  redirect/flush request.
- `jump_addr_in`  in  ADDR_W  redirect target.
- `hold_flag_in`  in  3  pipeline hold level (`HoldFlagBus`).
- `ibus_req_o`  out  1  bus read request.
- `ibus_addr_o`  out  ADDR_W  request address; stable while req high and not granted.
- `ibus_gnt_i`  in  1  request accepted this cycle.
- `ibus_rvalid_i`  in  1  read data valid, at least 1 cycle after gnt.
- `ibus_rdata_i`  in  INST_W  read data.
- `inst_o`  out  INST_W  instruction to decode.
- `inst_addr_o`  out  ADDR_W  address of `inst_o`.
- `inst_valid_o`  out  1  `inst_o` is a real instruction.
- `fetch_stall_o`  out  1  combinational; high = PC must not advance.

## Operation
- Reset values: state S_IDLE; `ibus_req_o`=0; `ibus_addr_o`=0; `inst_o`=NOP_INST; `inst_addr_o`=0; `inst_valid_o`=0; discard=0; buffer empty; `fetch_stall_o`=1. The bus slave shares `rst`, so no response survives reset.
- S_IDLE: on the first clock after reset deasserts, latch `req_addr`←`pc_in` and go to S_REQ.
- S_REQ: drive `ibus_req_o`=1 and `ibus_addr_o`=`req_addr`. On `ibus_gnt_i`, go to S_WAIT.
- S_WAIT: on `ibus_rvalid_i`, consume the response, then:
  - If discard=1: drop the data, clear discard, go to S_REQ.
  - Else, if hold < `HoldIf`: load the output register with {rdata, req_addr, valid=1}.
  - Else: write the response into the 1-entry skid buffer.
  - In both non-discard cases, set `req_addr`←`req_addr`+4, mod 2^ADDR_W, wrapping silently.
  - Go to S_REQ, or to S_FULL if the skid buffer is occupied.
- S_FULL: no request. When hold < `HoldIf`, move the buffer to the output, set it empty, and go to S_REQ.
- Hold ≥ `HoldIf`: the output register is frozen. Hold < `HoldIf` with no delivery this cycle: output becomes NOP, valid=0.
- `fetch_stall_o`=0 only in a cycle where a non-discarded instruction enters the output register (from the bus or the buffer); 1 otherwise.
- `jump_flag_in`=1, which has the highest priority:
  - `req_addr`←`jump_addr_in`; output←NOP, valid=0; buffer cleared.
  - Discard←1 if a request is granted-but-unanswered, or granted this cycle. A response arriving in the same cycle is dropped.
  - In S_REQ without gnt: the pending request completes at the old address and its response is discarded. The redirect address is used from the next request.
  - Next state: S_REQ, unless discard is pending, in which case S_WAIT.
- Reset mid-operation: immediate return to the reset values, regardless of state.

## Timing
- Zero-wait bus (gnt in the request cycle, rvalid 1 cycle later): 2 cycles per instruction. The output is registered and appears the cycle after rvalid.
- Latency from reset deassertion to the first request: 1 cycle.
- At most one outstanding request; a new request only begins the cycle after the previous response.
- Jump to first request at the new target: 1 cycle if nothing is in flight, otherwise 1 cycle after the discarded rvalid.

## Structure
- `defines.v` provides `InstAddressBus`, `InstBus`, `HoldFlagBus`, `HoldPc`/`HoldIf` encodings, `InstNop`, `JumpEnable`, `RstEnable`, `InstByteWidth`.
- `defines.v` also gains new state encodings `IfStateIdle`/`Req`/`Wait`/`Full` (2 bits).
- One sub-module is natural: `ifetch_skid`, a 1-entry data+addr buffer with full flag.

## Test plan
- Reset release with `pc_in`=0x0000_0000 and a zero-wait bus: requests go to 0x0, 0x4, 0x8. Each `inst_valid_o` pulse carries the matching rdata/addr, and `fetch_stall_o` is low exactly in the delivery cycles.
- Gnt delayed 3 cycles: `ibus_addr_o` stays constant and req stays high; a single delivery follows.
- Jump to 0x100 while in S_WAIT: the old response is dropped, the output shows NOP/valid=0, and the next request is 0x100.
- Hold=`HoldIf` when rvalid arrives: the output stays frozen and the buffer fills with no new request. On release, the buffered instruction is delivered and the next request is at +4.
- `req_addr`=0xFFFF_FFFC delivered: the next request is 0x0000_0000.
- `rst` asserted mid-S_WAIT, asynchronously between edges: all outputs take their reset values immediately. After release, the first request is at `pc_in`.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared encodings for the instruction fetch stage.
//   - bus widths and the bubble instruction
//   - pipeline hold level at which IF must stop delivering
//   - fetch FSM state encoding (2 bits)
package ifetch_pkg;

  localparam int InstAddrW     = 32;
  localparam int InstW         = 32;
  localparam int HoldW         = 3;
  localparam int InstByteWidth = 4;

  // addi x0,x0,0
  localparam logic [InstW-1:0] InstNop = 32'h0000_0013;

  // Hold levels at or above this value freeze the IF/ID boundary.
  localparam logic [HoldW-1:0] HoldIf = 3'b010;

  localparam logic JumpEnable = 1'b1;

  typedef enum logic [1:0] {
    IfStateIdle = 2'd0,
    IfStateReq  = 2'd1,
    IfStateWait = 2'd2,
    IfStateFull = 2'd3
  } if_state_e;

  function automatic logic hold_blocks_if(input logic [HoldW-1:0] hold);
    return hold >= HoldIf;
  endfunction

endpackage

// File: rtl/ifetch_skid.sv
// ifetch_skid: one-entry instruction/address buffer with a full flag.
// Catches a bus response that arrives while decode is holding IF.
// Ports:
//   clk, rst       clock, async active-high reset
//   i_clr          drop the entry (jump flush); wins over push/pop
//   i_push         capture i_inst/i_addr
//   i_pop          release the entry
//   o_full         entry is occupied
//   o_inst/o_addr  buffered instruction and its address
module ifetch_skid #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [INST_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_full,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_addr
);

  logic              r_full;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_inst <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_full <= 1'b1;
      r_inst <= i_inst;
      r_addr <= i_addr;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_inst = r_inst;
  assign o_addr = r_addr;

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage with single-outstanding bus reads.
// Seeds its fetch address from pc_in after reset, steps by 4 per accepted
// instruction, redirects on jumps and feeds the IF/ID boundary.
// Ports:
//   clk, rst                         clock, async active-high reset
//   pc_in                            start PC, sampled when leaving idle
//   jump_flag_in, jump_addr_in       redirect/flush request and target
//   hold_flag_in                     pipeline hold level
//   ibus_req_o, ibus_addr_o          read request and its address
//   ibus_gnt_i                       request accepted this cycle
//   ibus_rvalid_i, ibus_rdata_i      read response
//   inst_o, inst_addr_o, inst_valid_o  registered IF/ID outputs
//   fetch_stall_o                    high whenever no instruction is delivered
module ifetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrW,
  parameter int                INST_W   = InstW,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(InstNop)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              jump_flag_in,
  input  logic [ADDR_W-1:0] jump_addr_in,
  input  logic [HoldW-1:0]  hold_flag_in,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [INST_W-1:0] ibus_rdata_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              fetch_stall_o
);

  if_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_req_addr, w_req_addr_nxt;
  logic [ADDR_W-1:0] r_bus_addr;
  logic              r_discard, w_discard_nxt;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_addr;
  logic              r_inst_valid;

  logic              w_jump;
  logic              w_hold_ok;
  logic              w_resp;
  logic              w_take;
  logic              w_bus_deliver;
  logic              w_skid_push;
  logic              w_skid_pop;
  logic              w_skid_full;
  logic [INST_W-1:0] w_skid_inst;
  logic [ADDR_W-1:0] w_skid_addr;
  logic [ADDR_W-1:0] w_req_addr_inc;
  logic              w_new_req;

  assign w_jump         = (jump_flag_in == JumpEnable);
  assign w_hold_ok      = !hold_blocks_if(hold_flag_in);
  assign w_resp         = (r_state == IfStateWait) && ibus_rvalid_i;
  // A response that is neither flagged for discard nor killed by a jump.
  assign w_take         = w_resp && !r_discard && !w_jump;
  assign w_bus_deliver  = w_take && w_hold_ok;
  assign w_skid_push    = w_take && !w_hold_ok;
  assign w_skid_pop     = (r_state == IfStateFull) && w_hold_ok && !w_jump;
  assign w_req_addr_inc = r_req_addr + ADDR_W'(InstByteWidth);

  ifetch_skid #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_jump),
    .i_push (w_skid_push),
    .i_pop  (w_skid_pop),
    .i_inst (ibus_rdata_i),
    .i_addr (r_req_addr),
    .o_full (w_skid_full),
    .o_inst (w_skid_inst),
    .o_addr (w_skid_addr)
  );

  // Next-state / fetch-address / discard logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_addr_nxt = r_req_addr;
    w_discard_nxt  = r_discard;
    if (w_jump) begin
      w_req_addr_nxt = jump_addr_in;
      unique case (r_state)
        IfStateIdle: w_state_nxt = IfStateReq;
        IfStateReq: begin
          // Granted or not, the request on the bus belongs to the old
          // stream; its response must be thrown away.
          w_discard_nxt = 1'b1;
          w_state_nxt   = ibus_gnt_i ? IfStateWait : IfStateReq;
        end
        IfStateWait: begin
          if (ibus_rvalid_i) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = IfStateReq;
          end else begin
            w_discard_nxt = 1'b1;
            w_state_nxt   = IfStateWait;
          end
        end
        IfStateFull: w_state_nxt = IfStateReq;
        default:     w_state_nxt = IfStateIdle;
      endcase
    end else begin
      unique case (r_state)
        IfStateIdle: begin
          w_req_addr_nxt = pc_in;
          w_state_nxt    = IfStateReq;
        end
        IfStateReq: begin
          if (ibus_gnt_i) w_state_nxt = IfStateWait;
        end
        IfStateWait: begin
          if (ibus_rvalid_i) begin
            if (r_discard) begin
              w_discard_nxt = 1'b0;
              w_state_nxt   = IfStateReq;
            end else begin
              w_req_addr_nxt = w_req_addr_inc;
              w_state_nxt    = w_hold_ok ? IfStateReq : IfStateFull;
            end
          end
        end
        IfStateFull: begin
          if (w_hold_ok) w_state_nxt = IfStateReq;
        end
        default: w_state_nxt = IfStateIdle;
      endcase
    end
  end

  // The bus address is captured only when a fresh request starts, so a jump
  // that lands while a request waits for gnt leaves that address stable.
  assign w_new_req = (w_state_nxt == IfStateReq) && (r_state != IfStateReq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IfStateIdle;
      r_req_addr <= '0;
      r_bus_addr <= '0;
      r_discard  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_discard  <= w_discard_nxt;
      if (w_new_req) r_bus_addr <= w_req_addr_nxt;
    end
  end

  // IF/ID output register: jump flush, then delivery, then bubble unless held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst       <= NOP_INST;
      r_inst_addr  <= '0;
      r_inst_valid <= 1'b0;
    end else if (w_jump) begin
      r_inst       <= NOP_INST;
      r_inst_valid <= 1'b0;
    end else if (w_bus_deliver) begin
      r_inst       <= ibus_rdata_i;
      r_inst_addr  <= r_req_addr;
      r_inst_valid <= 1'b1;
    end else if (w_skid_pop && w_skid_full) begin
      r_inst       <= w_skid_inst;
      r_inst_addr  <= w_skid_addr;
      r_inst_valid <= 1'b1;
    end else if (w_hold_ok) begin
      r_inst       <= NOP_INST;
      r_inst_valid <= 1'b0;
    end
  end

  assign ibus_req_o    = (r_state == IfStateReq);
  assign ibus_addr_o   = r_bus_addr;
  assign inst_o        = r_inst;
  assign inst_addr_o   = r_inst_addr;
  assign inst_valid_o  = r_inst_valid;
  assign fetch_stall_o = !(w_bus_deliver || w_skid_pop);

endmodule
